divisor_restaurador: RTL
========================

DIVISOR_RESTAURADOR -- requirements
Module: divisor_restaurador

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port inicio, input, 1 bit: start request, sampled on clk.
REQ-004 SHALL have port A, input, 4 bits: unsigned dividend, sampled when a start is accepted.
REQ-005 SHALL have port B, input, 4 bits: unsigned divisor, sampled when a start is accepted.
REQ-006 SHALL have port quociente, output, 4 bits: registered quotient.
REQ-007 SHALL have port resto, output, 4 bits: registered remainder.
REQ-008 SHALL have port pronto, output, 1 bit: one-cycle pulse marking valid results.
REQ-009 SHALL have port ocupado, output, 1 bit: high while a division is in progress.
REQ-010 SHALL have port erro_div_zero, output, 1 bit: high when the last result came from B=0.
REQ-011 SHALL have no parameters; all widths are fixed.

Function
REQ-012 SHALL implement an FSM with states OCIOSO, CALCULA and FIM.
REQ-013 SHALL accept a start only in OCIOSO with inicio=1; A and B are then captured and later input changes SHALL NOT affect the operation.
REQ-014 SHALL ignore inicio while in CALCULA or FIM, with no effect on state, outputs or the pending result.
REQ-015 SHALL, on an accepted start with B!=0, load the 5-bit partial remainder R=0, the quotient shift register = A and the iteration counter = 0, then enter CALCULA.
REQ-016 SHALL perform one restoring step per cycle in CALCULA, in this order:
- shift the dividend MSB into R;
- compute the trial difference R - {0,B} as a 5-bit two's-complement subtraction (B inverted, carry-in 1);
- if the difference MSB is 0, keep the difference and shift in quotient bit 1;
- otherwise restore R and shift in quotient bit 0.
REQ-017 SHALL execute exactly 4 CALCULA cycles, counted by a 2-bit counter, then enter FIM.
REQ-018 SHALL, for a start accepted at edge N with B!=0, update quociente, resto and erro_div_zero=0 at edge N+5 and assert pronto during cycle N+5 only.
REQ-019 SHALL, for a start accepted at edge N with B=0, skip CALCULA and go straight to FIM, setting quociente=4'hF, resto=A and erro_div_zero=1 at edge N+1, with pronto during cycle N+1 only.
REQ-020 SHALL hold ocupado=1 from the accepting edge until the edge that enters FIM, and ocupado=0 in OCIOSO and FIM.
REQ-021 SHALL return from FIM to OCIOSO after one cycle; a start asserted during FIM SHALL be ignored and is accepted from the next cycle on.
REQ-022 SHALL hold quociente, resto and erro_div_zero stable between result updates.
REQ-023 SHALL produce results satisfying A = quociente*B + resto and resto < B for every B!=0 (all 240 combinations).
REQ-024 SHALL leave quociente and resto unchanged during CALCULA, using internal working registers only.

Reset
REQ-025 SHALL, when rst_n=0, immediately (no clock needed) force state=OCIOSO, quociente=0, resto=0, pronto=0, ocupado=0, erro_div_zero=0, and clear counter and working registers.
REQ-026 SHALL abort an in-progress division on reset mid-operation, with no pronto pulse for it afterwards.
REQ-027 SHALL accept a start at the first rising edge after rst_n deasserts.

Verification
REQ-028 SHALL cover: A=13, B=3, start at edge N -> ocupado 1 for N+1..N+4; pronto at N+5 with quociente=4, resto=1, erro_div_zero=0.
REQ-029 SHALL cover: A=15, B=1 -> quociente=15, resto=0; and A=2, B=7 -> quociente=0, resto=2; both at N+5.
REQ-030 SHALL cover: A=9, B=0 -> pronto at N+1, quociente=4'hF, resto=9, erro_div_zero=1, ocupado never 1.
REQ-031 SHALL cover: start A=12, B=5, then inicio=1 with A=1, B=1 at N+2 -> only one pronto, at N+5, with quociente=2, resto=2.
REQ-032 SHALL cover: rst_n pulled low at N+2 of a division -> outputs 0 immediately, no pronto; a new A=6, B=2 start after release -> quociente=3, resto=0.
REQ-033 SHALL cover: an exhaustive sweep of all 256 A/B pairs checked against REQ-019 and REQ-023.

Source files
------------

// File: rtl/divisor_restaurador.sv
// Restoring divider for 4-bit unsigned operands: one quotient bit per cycle,
// with a dedicated division-by-zero path that reports immediately.
module divisor_restaurador (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inicio,
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic [3:0] quociente,
    output logic [3:0] resto,
    output logic       pronto,
    output logic       ocupado,
    output logic       erro_div_zero
);

    typedef enum logic [1:0] {OCIOSO, CALCULA, FIM} estado_t;

    estado_t    estado;
    logic [4:0] r_reg;
    logic [3:0] q_reg;
    logic [3:0] b_reg;
    logic [1:0] cnt_reg;
    logic       zero_reg;

    logic [4:0] r_shift;
    logic [4:0] diff;

    // Trial subtraction: partial remainder minus {0,B}, via inverted B and carry-in.
    always_comb begin
        r_shift = {r_reg[3:0], q_reg[3]};
        diff    = r_shift + ~{1'b0, b_reg} + 5'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado        <= OCIOSO;
            r_reg         <= '0;
            q_reg         <= '0;
            b_reg         <= '0;
            cnt_reg       <= '0;
            zero_reg      <= 1'b0;
            quociente     <= '0;
            resto         <= '0;
            pronto        <= 1'b0;
            ocupado       <= 1'b0;
            erro_div_zero <= 1'b0;
        end else begin
            pronto <= 1'b0;
            case (estado)
                OCIOSO: begin
                    if (inicio) begin
                        b_reg    <= B;
                        q_reg    <= A;
                        r_reg    <= '0;
                        cnt_reg  <= '0;
                        zero_reg <= (B == 4'd0);
                        if (B == 4'd0) begin
                            estado <= FIM;
                        end else begin
                            estado  <= CALCULA;
                            ocupado <= 1'b1;
                        end
                    end
                end
                CALCULA: begin
                    if (!diff[4]) begin
                        r_reg <= diff;
                        q_reg <= {q_reg[2:0], 1'b1};
                    end else begin
                        r_reg <= r_shift;
                        q_reg <= {q_reg[2:0], 1'b0};
                    end
                    cnt_reg <= cnt_reg + 2'd1;
                    if (cnt_reg == 2'd3) begin
                        estado  <= FIM;
                        ocupado <= 1'b0;
                    end
                end
                FIM: begin
                    // On divide-by-zero q_reg still holds the untouched dividend.
                    quociente     <= zero_reg ? 4'hF : q_reg;
                    resto         <= zero_reg ? q_reg : r_reg[3:0];
                    erro_div_zero <= zero_reg;
                    pronto        <= 1'b1;
                    estado        <= OCIOSO;
                end
                default: estado <= OCIOSO;
            endcase
        end
    end

endmodule
